// File: rtl/ex_stage_pipe_pkg.sv
// Shared encodings for the execute stage: MIPS opcodes/functs, forwarding selects,
// ALU operation and mul/div state enums, and the instruction decoder.
package ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_ID  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO, ALU_MD
  } alu_op_e;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    ovf_chk;
    logic    zext;
    logic    md;
    logic    md_signed;
    logic    md_div;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:   d.op = ALU_SLL;
          FN_SRL:   d.op = ALU_SRL;
          FN_SRA:   d.op = ALU_SRA;
          FN_MFHI:  d.op = ALU_MFHI;
          FN_MFLO:  d.op = ALU_MFLO;
          FN_MULT:  begin d.op = ALU_MD; d.md = 1'b1; d.md_signed = 1'b1; end
          FN_MULTU: begin d.op = ALU_MD; d.md = 1'b1; end
          FN_DIV:   begin d.op = ALU_MD; d.md = 1'b1; d.md_signed = 1'b1; d.md_div = 1'b1; end
          FN_DIVU:  begin d.op = ALU_MD; d.md = 1'b1; d.md_div = 1'b1; end
          FN_ADD:   begin d.op = ALU_ADD; d.ovf_chk = 1'b1; end
          FN_ADDU:  d.op = ALU_ADD;
          FN_SUB:   begin d.op = ALU_SUB; d.ovf_chk = 1'b1; end
          FN_SUBU:  d.op = ALU_SUB;
          FN_AND:   d.op = ALU_AND;
          FN_OR:    d.op = ALU_OR;
          FN_XOR:   d.op = ALU_XOR;
          FN_NOR:   d.op = ALU_NOR;
          FN_SLT:   d.op = ALU_SLT;
          FN_SLTU:  d.op = ALU_SLTU;
          default:  d.op = ALU_NONE;
        endcase
      end
      OP_ADDI:  begin d.op = ALU_ADD; d.ovf_chk = 1'b1; end
      OP_ADDIU: d.op = ALU_ADD;
      OP_LW:    d.op = ALU_ADD;
      OP_SW:    d.op = ALU_ADD;
      OP_SLTI:  d.op = ALU_SLT;
      OP_SLTIU: d.op = ALU_SLTU;
      OP_ANDI:  begin d.op = ALU_AND; d.zext = 1'b1; end
      OP_ORI:   begin d.op = ALU_OR;  d.zext = 1'b1; end
      OP_XORI:  begin d.op = ALU_XOR; d.zext = 1'b1; end
      OP_LUI:   d.op = ALU_LUI;
      default:  d.op = ALU_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// ID/EX-side inputs, hazard-unit controls and EX/MEM outputs of the execute stage.
interface ex_stage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
);
  logic               in_valid;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  mem_fwd;
  logic [DATA_W-1:0]  wb_fwd;
  logic [1:0]         fwd_a_sel;
  logic [1:0]         fwd_b_sel;
  logic               use_imm;
  logic [REG_W-1:0]   dest_in;
  logic               hold;
  logic               stall;
  logic               out_valid;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  store_data;
  logic [REG_W-1:0]   dest_out;
  logic               ovf;
  logic               busy;

  modport master (
    output in_valid, opcode, funct, shamt, rs_data, rt_data, imm, mem_fwd, wb_fwd,
           fwd_a_sel, fwd_b_sel, use_imm, dest_in, hold,
    input  stall, out_valid, result, store_data, dest_out, ovf, busy
  );

  modport slave (
    input  in_valid, opcode, funct, shamt, rs_data, rt_data, imm, mem_fwd, wb_fwd,
           fwd_a_sel, fwd_b_sel, use_imm, dest_in, hold,
    output stall, out_valid, result, store_data, dest_out, ovf, busy
  );
endinterface

// File: rtl/ex_stage_pipe_muldiv.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, sign fix-up applied when HI/LO are written.
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic              i_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  import ex_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  md_state_e           r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_wh, r_wl, r_m, r_hi, r_lo;
  logic                r_div, r_neg_q, r_neg_r, r_dz;
  logic [DATA_W:0]     w_sum, w_rs, w_trial;
  logic [DATA_W-1:0]   w_nh, w_nl, w_qfix, w_rfix;
  logic [2*DATA_W-1:0] w_prod, w_pfix;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  always_comb begin
    w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_m} : '0);
    w_rs    = {r_wh, r_wl[DATA_W-1]};
    w_trial = w_rs - {1'b0, r_m};
    if (r_div) begin
      if (!w_trial[DATA_W]) begin
        w_nh = w_trial[DATA_W-1:0];
        w_nl = {r_wl[DATA_W-2:0], 1'b1};
      end else begin
        w_nh = w_rs[DATA_W-1:0];
        w_nl = {r_wl[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_nh = w_sum[DATA_W:1];
      w_nl = {w_sum[0], r_wl[DATA_W-1:1]};
    end
    w_prod = {w_nh, w_nl};
    w_pfix = r_neg_q ? -w_prod : w_prod;
    w_qfix = r_dz ? '1 : (r_neg_q ? -w_nl : w_nl);
    w_rfix = r_neg_r ? -w_nh : w_nh;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_wh    <= '0;
      r_wl    <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_RUN;
            r_cnt   <= '0;
            r_div   <= i_div;
            r_neg_q <= i_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_neg_r <= i_signed & i_div & i_a[DATA_W-1];
            r_dz    <= i_div & (i_b == '0);
            r_wh    <= '0;
            r_wl    <= i_div ? mag(i_a, i_signed) : mag(i_b, i_signed);
            r_m     <= i_div ? mag(i_b, i_signed) : mag(i_a, i_signed);
          end
        end
        MD_RUN: begin
          r_wh  <= w_nh;
          r_wl  <= w_nl;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= MD_IDLE;
            r_hi    <= r_div ? w_rfix : w_pfix[2*DATA_W-1:DATA_W];
            r_lo    <= r_div ? w_qfix : w_pfix[DATA_W-1:0];
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == MD_RUN);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: rtl/ex_stage_pipe.sv
// MIPS execute stage: operand forwarding, ALU, HI/LO via iterative mul/div,
// and the EX/MEM pipeline register with downstream hold and upstream stall.
module ex_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
) (
  input logic           clock,
  input logic           reset,
  ex_stage_pipe_if.slave bus
);
  import ex_pkg::*;

  localparam int IMM_W = (DATA_W < 16) ? DATA_W : 16;

  dec_t                      w_dec;
  logic [DATA_W-1:0]         w_a, w_b_fwd, w_b, w_zimm, w_lui, w_sum, w_diff, w_res, w_hi, w_lo;
  logic signed [DATA_W-1:0]  w_a_s, w_b_s;
  logic [SHAMT_W-1:0]        w_shamt;
  logic                      w_ovf, w_stall, w_accept, w_busy;

  logic                      r_vld_p1, r_ovf_p1;
  logic [DATA_W-1:0]         r_result_p1, r_store_p1;
  logic [REG_W-1:0]          r_dest_p1;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_dec   = decode(bus.opcode, bus.funct);
  assign w_shamt = bus.shamt;
  assign w_zimm  = DATA_W'(bus.imm[IMM_W-1:0]);
  assign w_lui   = w_zimm << 16;

  always_comb begin
    case (bus.fwd_a_sel)
      FWD_MEM: w_a = bus.mem_fwd;
      FWD_WB:  w_a = bus.wb_fwd;
      default: w_a = bus.rs_data;
    endcase
    case (bus.fwd_b_sel)
      FWD_MEM: w_b_fwd = bus.mem_fwd;
      FWD_WB:  w_b_fwd = bus.wb_fwd;
      default: w_b_fwd = bus.rt_data;
    endcase
  end

  // Logical immediates are zero-extended; every other immediate arrives sign-extended.
  assign w_b    = bus.use_imm ? (w_dec.zext ? w_zimm : bus.imm) : w_b_fwd;
  assign w_a_s  = signed'(w_a);
  assign w_b_s  = signed'(w_b);
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_dec.op)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = w_dec.ovf_chk & add_ovf(w_a[DATA_W-1], w_b[DATA_W-1], w_sum[DATA_W-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = w_dec.ovf_chk & add_ovf(w_a[DATA_W-1], ~w_b[DATA_W-1], w_diff[DATA_W-1]);
      end
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      ALU_NOR:  w_res = ~(w_a | w_b);
      ALU_SLT:  w_res = {{(DATA_W-1){1'b0}}, (w_a_s < w_b_s)};
      ALU_SLTU: w_res = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
      ALU_SLL:  w_res = w_b << w_shamt;
      ALU_SRL:  w_res = w_b >> w_shamt;
      ALU_SRA:  w_res = unsigned'(w_b_s >>> w_shamt);
      ALU_LUI:  w_res = w_lui;
      ALU_MFHI: w_res = w_hi;
      ALU_MFLO: w_res = w_lo;
      default:  w_res = '0;
    endcase
  end

  assign w_stall  = bus.in_valid & w_busy &
                    (w_dec.md | (w_dec.op == ALU_MFHI) | (w_dec.op == ALU_MFLO));
  assign w_accept = bus.in_valid & ~w_stall & ~bus.hold;

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clock    (clock),
    .reset    (reset),
    .i_start  (w_accept & w_dec.md),
    .i_signed (w_dec.md_signed),
    .i_div    (w_dec.md_div),
    .i_a      (w_a),
    .i_b      (w_b_fwd),
    .o_busy   (w_busy),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // EX/MEM boundary
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_store_p1  <= '0;
      r_dest_p1   <= '0;
      r_ovf_p1    <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1    <= 1'b1;
      r_result_p1 <= w_res;
      r_store_p1  <= w_b_fwd;
      r_dest_p1   <= (w_ovf || w_dec.md || (w_dec.op == ALU_NONE)) ? '0 : bus.dest_in;
      r_ovf_p1    <= w_ovf;
    end else if (!bus.hold) begin
      r_vld_p1    <= 1'b0;
    end
  end

  assign bus.stall      = w_stall;
  assign bus.busy       = w_busy;
  assign bus.out_valid  = r_vld_p1;
  assign bus.result     = r_result_p1;
  assign bus.store_data = r_store_p1;
  assign bus.dest_out   = r_dest_p1;
  assign bus.ovf        = r_ovf_p1;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU vector table plus mul/div, hold and reset sequences.
module tb_ex_stage_pipe;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ex_stage_pipe_if #(.DATA_W(W), .SHAMT_W(5), .REG_W(5)) bus();

  ex_stage_pipe #(.DATA_W(W), .SHAMT_W(5), .REG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs, rt, imm, memf, wbf;
    logic [1:0]  fa, fb;
    logic        ui;
    logic [4:0]  dst;
    logic [31:0] e_res;
    logic [4:0]  e_dst;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t rv(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                              input logic ui, input logic [4:0] dst, input logic [31:0] er,
                              input logic [4:0] ed, input logic eo);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.rs = rs; v.rt = rt; v.imm = imm;
    v.memf = '0; v.wbf = '0; v.fa = 2'd0; v.fb = 2'd0; v.ui = ui; v.dst = dst;
    v.e_res = er; v.e_dst = ed; v.e_ovf = eo;
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_v(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.opcode    = v.op;
    bus.funct     = v.fn;
    bus.shamt     = v.sh;
    bus.rs_data   = v.rs;
    bus.rt_data   = v.rt;
    bus.imm       = v.imm;
    bus.mem_fwd   = v.memf;
    bus.wb_fwd    = v.wbf;
    bus.fwd_a_sel = v.fa;
    bus.fwd_b_sel = v.fb;
    bus.use_imm   = v.ui;
    bus.dest_in   = v.dst;
  endtask

  task automatic issue_r(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] dst);
    drive_v(rv(6'h00, fn, 5'd0, rs, rt, 32'h0, 1'b0, dst, 32'h0, 5'd0, 1'b0));
  endtask

  task automatic wait_unstall(output int n);
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int   n;

    bus.in_valid = 1'b0; bus.opcode = '0; bus.funct = '0; bus.shamt = '0;
    bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0; bus.mem_fwd = '0; bus.wb_fwd = '0;
    bus.fwd_a_sel = '0; bus.fwd_b_sel = '0; bus.use_imm = 1'b0; bus.dest_in = '0;
    bus.hold = 1'b0;

    reset = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_store", bus.store_data, 32'd0);
    chk("rst_dest", 32'(bus.dest_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;

    // op, fn, sh, rs, rt, imm, use_imm, dst, exp result, exp dest, exp ovf
    vq.push_back(rv(6'h00, 6'h20, 5'd0, 32'd7, 32'd5, 32'h0, 1'b0, 5'd3, 32'd12, 5'd3, 1'b0));
    t = rv(6'h00, 6'h22, 5'd0, 32'h99, 32'h99, 32'h0, 1'b0, 5'd4, 32'h0000000D, 5'd4, 1'b0);
    t.fa = 2'd1; t.memf = 32'h10; t.fb = 2'd2; t.wbf = 32'd3;
    vq.push_back(t);
    vq.push_back(rv(6'h00, 6'h20, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h0, 1'b0, 5'd5, 32'h80000000, 5'd0, 1'b1));
    vq.push_back(rv(6'h00, 6'h21, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h0, 1'b0, 5'd5, 32'h80000000, 5'd5, 1'b0));
    vq.push_back(rv(6'h00, 6'h22, 5'd0, 32'h80000000, 32'd1, 32'h0, 1'b0, 5'd6, 32'h7FFFFFFF, 5'd0, 1'b1));
    vq.push_back(rv(6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 5'd7, 32'd1, 5'd7, 1'b0));
    vq.push_back(rv(6'h00, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 5'd7, 32'd0, 5'd7, 1'b0));
    vq.push_back(rv(6'h00, 6'h03, 5'd4, 32'h0, 32'h80000000, 32'h0, 1'b0, 5'd8, 32'hF8000000, 5'd8, 1'b0));
    vq.push_back(rv(6'h00, 6'h00, 5'd31, 32'h0, 32'd1, 32'h0, 1'b0, 5'd8, 32'h80000000, 5'd8, 1'b0));
    vq.push_back(rv(6'h00, 6'h02, 5'd4, 32'h0, 32'h80000000, 32'h0, 1'b0, 5'd8, 32'h08000000, 5'd8, 1'b0));
    vq.push_back(rv(6'h00, 6'h27, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd9, 32'hFFFFFFFF, 5'd9, 1'b0));
    vq.push_back(rv(6'h0C, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFF8001, 1'b1, 5'd8, 32'h00008001, 5'd8, 1'b0));
    vq.push_back(rv(6'h0F, 6'h00, 5'd0, 32'h0, 32'h0, 32'h00001234, 1'b1, 5'd8, 32'h12340000, 5'd8, 1'b0));
    vq.push_back(rv(6'h0A, 6'h00, 5'd0, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFD, 1'b1, 5'd8, 32'd1, 5'd8, 1'b0));
    vq.push_back(rv(6'h08, 6'h00, 5'd0, 32'h7FFFFFF0, 32'h0, 32'h20, 1'b1, 5'd8, 32'h80000010, 5'd0, 1'b1));
    vq.push_back(rv(6'h09, 6'h00, 5'd0, 32'h7FFFFFF0, 32'h0, 32'h20, 1'b1, 5'd8, 32'h80000010, 5'd8, 1'b0));
    vq.push_back(rv(6'h23, 6'h00, 5'd0, 32'h100, 32'h0, 32'd4, 1'b1, 5'd10, 32'h104, 5'd10, 1'b0));
    t = rv(6'h00, 6'h26, 5'd0, 32'hF0, 32'hFF, 32'h0, 1'b0, 5'd11, 32'h0F, 5'd11, 1'b0);
    t.fa = 2'd3;
    vq.push_back(t);
    vq.push_back(rv(6'h3F, 6'h00, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 5'd9, 32'd0, 5'd0, 1'b0));
    vq.push_back(rv(6'h0D, 6'h00, 5'd0, 32'h00010000, 32'h0, 32'hFFFF00F0, 1'b1, 5'd12, 32'h000100F0, 5'd12, 1'b0));

    foreach (vq[i]) begin
      drive_v(vq[i]);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), bus.result, vq[i].e_res);
      chk($sformatf("v%0d_dest", i), 32'(bus.dest_out), 32'(vq[i].e_dst));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vq[i].e_ovf));
    end

    t = rv(6'h2B, 6'h00, 5'd0, 32'h100, 32'h5555, 32'd8, 1'b1, 5'd0, 32'h0, 5'd0, 1'b0);
    t.fb = 2'd1; t.memf = 32'hABCD;
    drive_v(t);
    tick();
    chk("sw_addr", bus.result, 32'h108);
    chk("sw_store", bus.store_data, 32'hABCD);

    bus.in_valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);

    // MULT -3*5, then MFLO/MFHI back to back
    issue_r(6'h18, 32'hFFFFFFFD, 32'd5, 5'd3);
    tick();
    chk("mult_valid", 32'(bus.out_valid), 32'd1);
    chk("mult_dest", 32'(bus.dest_out), 32'd0);
    chk("mult_busy", 32'(bus.busy), 32'd1);
    issue_r(6'h12, 32'h0, 32'h0, 5'd10);
    wait_unstall(n);
    chk("mult_stall_cycles", 32'(n), 32'd32);
    tick();
    chk("mult_lo", bus.result, 32'hFFFFFFF1);
    chk("mflo_dest", 32'(bus.dest_out), 32'd10);
    issue_r(6'h10, 32'h0, 32'h0, 5'd10);
    tick();
    chk("mult_hi", bus.result, 32'hFFFFFFFF);

    // DIV -7/2 with an independent ADD passing while busy
    issue_r(6'h1A, 32'hFFFFFFF9, 32'd2, 5'd3);
    tick();
    issue_r(6'h20, 32'd2, 32'd2, 5'd11);
    #1;
    chk("add_under_busy_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("add_under_busy_res", bus.result, 32'd4);
    chk("add_under_busy_busy", 32'(bus.busy), 32'd1);
    issue_r(6'h12, 32'h0, 32'h0, 5'd10);
    wait_unstall(n);
    tick();
    chk("div_lo", bus.result, 32'hFFFFFFFD);
    issue_r(6'h10, 32'h0, 32'h0, 5'd10);
    tick();
    chk("div_hi", bus.result, 32'hFFFFFFFF);

    // DIVU 9/0
    issue_r(6'h1B, 32'd9, 32'd0, 5'd3);
    tick();
    issue_r(6'h12, 32'h0, 32'h0, 5'd10);
    wait_unstall(n);
    chk("divu_stall_cycles", 32'(n), 32'd32);
    tick();
    chk("divz_lo", bus.result, 32'hFFFFFFFF);
    issue_r(6'h10, 32'h0, 32'h0, 5'd10);
    tick();
    chk("divz_hi", bus.result, 32'd9);

    // hold for 3 cycles with a waiting instruction
    issue_r(6'h20, 32'd1, 32'd1, 5'd2);
    tick();
    chk("pre_hold_res", bus.result, 32'd2);
    issue_r(6'h20, 32'd3, 32'd4, 5'd4);
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d_res", k), bus.result, 32'd2);
      chk($sformatf("hold%0d_dest", k), 32'(bus.dest_out), 32'd2);
    end
    bus.hold = 1'b0;
    tick();
    chk("post_hold_res", bus.result, 32'd7);
    chk("post_hold_dest", 32'(bus.dest_out), 32'd4);
    bus.in_valid = 1'b0;
    tick();
    chk("post_hold_bubble", 32'(bus.out_valid), 32'd0);

    // reset during RUN clears HI/LO and busy
    issue_r(6'h19, 32'h12345678, 32'd3, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("run10_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("rst_run_busy", 32'(bus.busy), 32'd0);
    chk("rst_run_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b1;
    issue_r(6'h10, 32'h0, 32'h0, 5'd10);
    #1;
    chk("rst_run_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("rst_run_hi", bus.result, 32'd0);
    issue_r(6'h12, 32'h0, 32'h0, 5'd10);
    tick();
    chk("rst_run_lo", bus.result, 32'd0);
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
